// File: rtl/serial_adder_seq_pkg.sv
// Shared types and helpers for the bit-serial adder/subtractor: FSM state
// encoding, operation select constants and the bit-counter width function.
package serial_adder_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // ceil(log2(w)), never less than 1 so the counter always has a bit
    function automatic int cnt_width(input int w);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < w) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/serial_full_adder.sv
// Combinational 1-bit full adder cell used once by the serial datapath.
module serial_full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder_seq.sv
// Bit-serial adder/subtractor, LSB first through one full-adder cell, with a
// start/done handshake. Define SERIAL_ADDER_SEQ_OVF_EN to add the ovf output.
module serial_adder_seq
    import serial_adder_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    input  logic             sub,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             cout
`ifdef SERIAL_ADDER_SEQ_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_s;
    logic             fa_c;
    logic             last_bit;
    logic             load;
    logic             shift_en;
    logic             finish;

    serial_full_adder u_fa (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_c)
    );

    assign last_bit = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = SHIFT;
            SHIFT:   if (last_bit) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        load     = (state == IDLE) && start;
        shift_en = (state == SHIFT);
        finish   = (state == DONE);
    end

    // Outputs are registered one cycle behind the state, so busy and done
    // trail SHIFT/DONE by a clock and out/cout change only with done.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            out    <= '0;
            cout   <= 1'b0;
        end else begin
            busy <= (state != IDLE);
            done <= finish;
            if (load) begin
                a_sr  <= data_a;
                b_sr  <= (sub == OP_SUB) ? ~data_b : data_b;
                carry <= (sub == OP_SUB) ? 1'b1 : cin;
                cnt   <= '0;
            end
            if (shift_en) begin
                a_sr   <= a_sr >> 1;
                b_sr   <= b_sr >> 1;
                res_sr <= {fa_s, res_sr[WIDTH-1:1]};
                carry  <= fa_c;
                cnt    <= cnt + 1'b1;
            end
            if (finish) begin
                out  <= res_sr;
                cout <= carry;
            end
        end
    end

`ifdef SERIAL_ADDER_SEQ_OVF_EN
    // Carry entering the MSB cell; XOR with the final carry gives signed overflow
    logic msb_cin;

    always_ff @(posedge clk) begin
        if (reset) begin
            msb_cin <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            if (shift_en && last_bit) msb_cin <= carry;
            if (finish) ovf <= msb_cin ^ carry;
        end
    end
`endif

endmodule

// File: tb/tb_serial_adder_seq.sv
// Directed, table-driven bench for serial_adder_seq at WIDTH=4 and WIDTH=8.
module tb_serial_adder_seq;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start4 = 1'b0, sub4 = 1'b0, cin4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       busy4, done4, cout4;
    logic [3:0] out4;
    logic       start8 = 1'b0, sub8 = 1'b0, cin8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, cout8;
    logic [7:0] out8;
`ifdef SERIAL_ADDER_SEQ_OVF_EN
    logic       ovf4, ovf8;
`endif

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    serial_adder_seq #(.WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .data_a(a4), .data_b(b4),
        .sub(sub4), .cin(cin4), .busy(busy4), .done(done4), .out(out4), .cout(cout4)
`ifdef SERIAL_ADDER_SEQ_OVF_EN
        , .ovf(ovf4)
`endif
    );

    serial_adder_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .data_a(a8), .data_b(b8),
        .sub(sub8), .cin(cin8), .busy(busy8), .done(done8), .out(out8), .cout(cout8)
`ifdef SERIAL_ADDER_SEQ_OVF_EN
        , .ovf(ovf8)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       sub;
        logic       cin;
        logic [3:0] eo;
        logic       ec;
        logic       ev;
    } vec_t;

    vec_t vecs[11];

    // One WIDTH=4 operation; operands are scrambled right after the accept edge
    task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic s, input logic c,
                        output logic [3:0] o, output logic co, output logic ov,
                        output int lat, output logic b1, output logic bd, output logic ba);
        @(negedge clk);
        a4 = a; b4 = b; sub4 = s; cin4 = c; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0; a4 = ~a; b4 = ~b; sub4 = ~s; cin4 = ~c;
        lat = 0; b1 = 1'b0; o = '0; co = 1'b0; ov = 1'b0; bd = 1'b0; ba = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (i == 1) b1 = busy4;
            if (done4) begin
                lat = i; o = out4; co = cout4; bd = busy4;
`ifdef SERIAL_ADDER_SEQ_OVF_EN
                ov = ovf4;
`endif
                break;
            end
        end
        @(posedge clk); #1;
        ba = busy4;
    endtask

    initial begin
        logic [3:0] o;
        logic       co, ov, b1, bd, ba;
        int         lat, ndone, s, ea, eb, es;

        vecs[0]  = '{4'b1010, 4'b1010, 1'b0, 1'b0, 4'b0100, 1'b1, 1'b1};
        vecs[1]  = '{4'b1100, 4'b1101, 1'b0, 1'b0, 4'b1001, 1'b1, 1'b0};
        vecs[2]  = '{4'b0101, 4'b0011, 1'b1, 1'b0, 4'b0010, 1'b1, 1'b0};
        vecs[3]  = '{4'b0101, 4'b0011, 1'b1, 1'b1, 4'b0010, 1'b1, 1'b0};
        vecs[4]  = '{4'b0011, 4'b0101, 1'b1, 1'b0, 4'b1110, 1'b0, 1'b0};
        vecs[5]  = '{4'b0011, 4'b0101, 1'b1, 1'b1, 4'b1110, 1'b0, 1'b0};
        vecs[6]  = '{4'b1111, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b1, 1'b0};
        vecs[7]  = '{4'b0111, 4'b0001, 1'b0, 1'b0, 4'b1000, 1'b0, 1'b1};
        vecs[8]  = '{4'b1000, 4'b0001, 1'b1, 1'b0, 4'b0111, 1'b1, 1'b1};
        vecs[9]  = '{4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0};
        vecs[10] = '{4'b0110, 4'b0011, 1'b0, 1'b1, 4'b1010, 1'b0, 1'b1};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy4", busy4, 1'b0);
        check("rst_done4", done4, 1'b0);
        check("rst_out4", out4, 4'h0);
        check("rst_cout4", cout4, 1'b0);
        check("rst_busy8", busy8, 1'b0);
        check("rst_out8", out8, 8'h00);
        reset = 1'b0;

        for (int v = 0; v < 11; v++) begin
            run4(vecs[v].a, vecs[v].b, vecs[v].sub, vecs[v].cin, o, co, ov, lat, b1, bd, ba);
            check($sformatf("v%0d_latency", v), lat, 5);
            check($sformatf("v%0d_out", v), o, vecs[v].eo);
            check($sformatf("v%0d_cout", v), co, vecs[v].ec);
            check($sformatf("v%0d_busy_first", v), b1, 1'b1);
            check($sformatf("v%0d_busy_at_done", v), bd, 1'b1);
            check($sformatf("v%0d_busy_after", v), ba, 1'b0);
`ifdef SERIAL_ADDER_SEQ_OVF_EN
            check($sformatf("v%0d_ovf", v), ov, vecs[v].ev);
`endif
        end

        // Reset on the third SHIFT edge aborts; previous out (1010) is lost
        @(negedge clk);
        a4 = 4'b0101; b4 = 4'b0001; sub4 = 1'b0; cin4 = 1'b0; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_busy", busy4, 1'b0);
        check("abort_out", out4, 4'h0);
        check("abort_done", done4, 1'b0);
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (done4) ndone++;
        end
        check("abort_no_done", ndone, 0);
        run4(4'b0011, 4'b0100, 1'b0, 1'b0, o, co, ov, lat, b1, bd, ba);
        check("after_abort_latency", lat, 5);
        check("after_abort_out", o, 4'b0111);
        check("after_abort_cout", co, 1'b0);

        // WIDTH=8: FF+01 with a second start and operand changes during SHIFT
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'h01; sub8 = 1'b0; cin8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0; a8 = 8'h12; b8 = 8'h34;
        ndone = 0; lat = 0; o = '0;
        for (int i = 1; i <= 25; i++) begin
            if (i == 3) start8 = 1'b1;
            if (i == 4) start8 = 1'b0;
            @(posedge clk); #1;
            if (done8) begin
                ndone++;
                if (lat == 0) begin
                    lat = i;
                    check("w8_out", out8, 8'h00);
                    check("w8_cout", cout8, 1'b1);
                end
            end
        end
        check("w8_latency", lat, 9);
        check("w8_single_done", ndone, 1);

        // Back-to-back: start held high, accepts every 6 cycles at WIDTH=4
        repeat (2) @(posedge clk);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            a4 = 4'(c * 5 + 1); b4 = 4'(c * 3 + 2); sub4 = 1'b0; cin4 = 1'b0; start4 = 1'b1;
            @(posedge clk); #1;
            check($sformatf("b2b_done_c%0d", c), done4, (c >= 5) && ((c - 5) % 6 == 0));
            if (done4) begin
                s  = c - 5;
                ea = (s * 5 + 1) & 15;
                eb = (s * 3 + 2) & 15;
                es = ea + eb;
                check($sformatf("b2b_out_c%0d", c), out4, 4'(es & 15));
                check($sformatf("b2b_cout_c%0d", c), cout4, (es >> 4) & 1);
            end
        end
        @(negedge clk);
        start4 = 1'b0;
        repeat (10) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
